// File: rtl/amostrador_contador.sv
// amostrador_contador: two-flop synchronizer plus stability filter for a ripple-counter bus, with wrap counting
// Optional +1 sequence checker on accepted values: define AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
module amostrador_contador #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  valor,
  output logic              novo,
  output logic              volta,
  output logic [WRAP_W-1:0] voltas,
  output logic              erro
);
  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] FILTRA  = 2'd1;
  localparam logic [1:0] ESTAVEL = 2'd2;
  localparam logic [3:0] EST_MAX = 4'(STABLE - 1);

  logic [WIDTH-1:0]  s1_q, s2_q, cand_q, cand_d, valor_q, valor_d;
  logic [3:0]        est_q, est_d;
  logic [1:0]        state_q, state_d;
  logic              novo_q, novo_d, volta_q, volta_d, accept, wrap;
  logic [WRAP_W-1:0] voltas_q, voltas_d;
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
  logic              erro_q, erro_d;
`endif

  assign wrap = (valor_q == '1) && (cand_q == '0);

  // Filter FSM: a value must be seen unchanged on s2 for STABLE+1 edges before it is published
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    est_d    = est_q;
    valor_d  = valor_q;
    voltas_d = voltas_q;
    novo_d   = 1'b0;
    volta_d  = 1'b0;
    accept   = 1'b0;
    if (!en) state_d = OCIOSO;
    else begin
      case (state_q)
        OCIOSO: begin
          state_d = FILTRA;
          cand_d  = s2_q;
          est_d   = 4'd0;
        end
        FILTRA: begin
          if (s2_q != cand_q) begin
            cand_d = s2_q;
            est_d  = 4'd0;
          end else if (est_q != EST_MAX) est_d = est_q + 4'd1;
          else begin
            state_d = ESTAVEL;
            accept  = 1'b1;
          end
        end
        ESTAVEL: begin
          if (s2_q != valor_q) begin
            state_d = FILTRA;
            cand_d  = s2_q;
            est_d   = 4'd0;
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
    if (accept && cand_q != valor_q) begin
      valor_d = cand_q;
      novo_d  = 1'b1;
      volta_d = wrap;
      if (wrap && voltas_q != '1) voltas_d = voltas_q + 1'b1;
    end
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
    erro_d = erro_q | (accept && cand_q != valor_q && cand_q != WIDTH'(valor_q + 1'b1));
`endif
  end

  // State and output registers; clr clears everything without waiting for clk
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      est_q    <= '0;
      state_q  <= OCIOSO;
      valor_q  <= '0;
      novo_q   <= 1'b0;
      volta_q  <= 1'b0;
      voltas_q <= '0;
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      s1_q     <= q_in;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      est_q    <= est_d;
      state_q  <= state_d;
      valor_q  <= valor_d;
      novo_q   <= novo_d;
      volta_q  <= volta_d;
      voltas_q <= voltas_d;
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign valor  = valor_q;
  assign novo   = novo_q;
  assign volta  = volta_q;
  assign voltas = voltas_q;
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
  assign erro   = erro_q;
`else
  assign erro   = 1'b0;
`endif
endmodule

// File: tb/tb_amostrador_contador.sv
// tb_amostrador_contador: vector table, directed corner sequences and random stimulus against a window-based model
module tb_amostrador_contador;
  localparam int W = 4, ST = 2, WW = 8;
`ifdef AMOSTRADOR_CONTADOR_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0, clr = 1'b1, en = 1'b0;
  logic [W-1:0] q_in = '0;
  logic [W-1:0] valor;
  logic novo, volta, erro;
  logic [WW-1:0] voltas;

  amostrador_contador #(.WIDTH(W), .STABLE(ST), .WRAP_W(WW)) dut (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in),
    .valor(valor), .novo(novo), .volta(volta), .voltas(voltas), .erro(erro)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: a value is published when en was high and s2 held it on each of the last STABLE+1 edges
  logic [W-1:0] m_s1, m_s2, m_valor;
  logic m_novo, m_volta, m_erro;
  logic [WW-1:0] m_voltas;
  logic [W-1:0] w_v[$];
  logic w_e[$];

  typedef struct {
    logic [W-1:0] q;
    logic e;
    int cyc;
    logic [W-1:0] xv;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_s1 = '0; m_s2 = '0; m_valor = '0; m_novo = 0; m_volta = 0; m_erro = 0; m_voltas = '0;
    w_v.delete(); w_e.delete();
  endtask

  task automatic model_edge();
    logic ok;
    logic [W-1:0] v;
    w_v.push_back(m_s2);
    w_e.push_back(en);
    if (w_v.size() > ST + 1) begin
      void'(w_v.pop_front());
      void'(w_e.pop_front());
    end
    m_novo = 0;
    m_volta = 0;
    if (w_v.size() == ST + 1) begin
      v = w_v[ST];
      ok = 1;
      for (int i = 0; i <= ST; i++) if (!w_e[i] || w_v[i] != v) ok = 0;
      if (ok && v != m_valor) begin
        m_novo = 1;
        if (m_valor == {W{1'b1}} && v == '0) begin
          m_volta = 1;
          if (m_voltas != {WW{1'b1}}) m_voltas = m_voltas + 1'b1;
        end
        if (EXP_ERR && v != W'(m_valor + 1'b1)) m_erro = 1;
        m_valor = v;
      end
    end
    m_s2 = m_s1;
    m_s1 = q_in;
  endtask

  task automatic compare_all();
    chk("m_valor", valor, m_valor);
    chk("m_novo", novo, m_novo);
    chk("m_volta", volta, m_volta);
    chk("m_voltas", voltas, m_voltas);
    chk("m_erro", erro, m_erro);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!clr) mreset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_clr();
    clr = 1'b0;
    #1;
    mreset();
    compare_all();
  endtask

  task automatic do_reset();
    q_in = '0;
    en = 1'b1;
    async_clr();
    tick();
    tick();
    clr = 1'b1;
    repeat (8) tick();
  endtask

  task automatic hold(input logic [W-1:0] q, input int n);
    q_in = q;
    repeat (n) tick();
  endtask

  initial begin
    int nn, nv, bad;
    mreset();
    // Reset with a nonzero counter value waiting on the input
    #2;
    q_in = 4'd9;
    en = 1'b1;
    async_clr();
    chk("rst_valor", valor, 0);
    chk("rst_novo", novo, 0);
    chk("rst_voltas", voltas, 0);
    repeat (3) tick();
    clr = 1'b1;
    repeat (4) tick();
    chk("rst_lat4_valor", valor, 0);
    tick();
    chk("rst_lat5_valor", valor, 9);
    chk("rst_lat5_novo", novo, 1);
    chk("rst_erro", erro, EXP_ERR);

    // Single step 0->1: exactly five edges of latency, one-cycle strobe
    do_reset();
    q_in = 4'd1;
    repeat (4) tick();
    chk("step_pre_valor", valor, 0);
    chk("step_pre_novo", novo, 0);
    tick();
    chk("step_valor", valor, 1);
    chk("step_novo", novo, 1);
    chk("step_volta", volta, 0);
    tick();
    chk("step_novo_off", novo, 0);

    // Table: legal steps, short glitches, enable gating
    tbl[0] = '{4'd2, 1'b1, 8, 4'd2};
    tbl[1] = '{4'd3, 1'b1, 8, 4'd3};
    tbl[2] = '{4'd7, 1'b1, 1, 4'd3};
    tbl[3] = '{4'd3, 1'b1, 8, 4'd3};
    tbl[4] = '{4'd7, 1'b1, 2, 4'd3};
    tbl[5] = '{4'd3, 1'b1, 8, 4'd3};
    tbl[6] = '{4'd4, 1'b1, 8, 4'd4};
    tbl[7] = '{4'd5, 1'b0, 8, 4'd4};
    tbl[8] = '{4'd5, 1'b1, 8, 4'd5};
    tbl[9] = '{4'd6, 1'b1, 8, 4'd6};
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].e;
      hold(tbl[i].q, tbl[i].cyc);
      chk($sformatf("tbl%0d_valor", i), valor, tbl[i].xv);
      chk($sformatf("tbl%0d_erro", i), erro, 0);
    end

    // Full wrap 1..15,0 from a cleared valor
    do_reset();
    nn = 0; nv = 0; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      q_in = W'(k);
      repeat (8) begin
        tick();
        if (novo) nn++;
        if (volta) begin
          nv++;
          if (!novo || valor != 0) bad++;
        end
      end
    end
    chk("wrap_novo_count", nn, 16);
    chk("wrap_volta_count", nv, 1);
    chk("wrap_volta_coinc", bad, 0);
    chk("wrap_voltas", voltas, 1);
    for (int r = 0; r < 299; r++)
      for (int k = 1; k <= 16; k++) hold(W'(k), 4);
    chk("wrap_sat", voltas, 255);
    chk("wrap_erro", erro, 0);

    // Non-increment acceptance
    do_reset();
    hold(4'd1, 8);
    hold(4'd2, 8);
    hold(4'd5, 8);
    chk("seq_valor", valor, 5);
    chk("seq_erro", erro, EXP_ERR);
    hold(4'd6, 8);
    hold(4'd7, 8);
    chk("seq_erro_sticky", erro, EXP_ERR);

    // clr two cycles into filtering, then clr while novo is high
    do_reset();
    hold(4'd1, 8);
    q_in = 4'd2;
    repeat (4) tick();
    #2;
    async_clr();
    chk("mclr_valor", valor, 0);
    tick();
    clr = 1'b1;
    repeat (3) begin
      tick();
      chk("mclr_no_novo", novo, 0);
    end
    repeat (2) tick();
    chk("mclr_new_novo", novo, 1);
    #2;
    async_clr();
    chk("mclr_novo_cut", novo, 0);
    tick();
    clr = 1'b1;

    // en dropped during filtering
    do_reset();
    hold(4'd1, 8);
    q_in = 4'd2;
    repeat (3) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("endrop_valor", valor, 1);
    chk("endrop_novo", novo, 0);
    repeat (6) tick();
    chk("endrop_resume", valor, 2);

    // Random input activity with occasional enable drops
    do_reset();
    for (int s = 0; s < 400; s++) begin
      en = ($urandom_range(0, 9) != 0);
      hold(W'($urandom_range(0, 15)), $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/amostrador_contador.md
# amostrador_contador

Synchronizing sampler placed directly downstream of the 4-bit asynchronous (ripple) counter. It brings the counter's skewed, glitch-prone `q` bus into the `clk` domain through a two-flop synchronizer and accepts a value only after it has been stable for `STABLE` cycles. Accepted values are published with a one-cycle `novo` strobe. The block also counts wrap-arounds and flags any accepted step that is not a +1 increment.

## Interface
- `WIDTH`, 4: width of the sampled counter bus.
- `STABLE`, 2: consecutive matching cycles required before acceptance; legal range 1..15.
- `WRAP_W`, 8: width of the wrap counter.

- `clk`  in  1  system clock; all logic on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `en`  in  1  sampling enable; synchronous to `clk`.
- `q_in`  in  WIDTH  raw ripple-counter output; asynchronous to `clk`.
- `valor`  out  WIDTH  last accepted stable value.
- `novo`  out  1  one-cycle pulse in the cycle after `valor` changes.
- `volta`  out  1  one-cycle pulse, coincident with `novo`, on an accepted wrap from all-ones to 0.
- `voltas`  out  WRAP_W  number of accepted wraps; saturates at all-ones.
- `erro`  out  1  sticky sequence-error flag (see Configuration).

## Operation
- Synchronizer: `s1 <= q_in`, `s2 <= s1` every cycle, regardless of `en` and state.
- Internal registers:
  - `cand`, candidate value, WIDTH bits.
  - `est`, stability counter, 4 bits.
  - FSM with states OCIOSO, FILTRA, ESTAVEL.
- OCIOSO:
  - All outputs hold. `novo` and `volta` are 0.
  - `en=1`: go to FILTRA with `cand<=s2` and `est<=0`.
- FILTRA:
  - `s2!=cand`: `cand<=s2`, `est<=0`, stay in FILTRA.
  - `s2==cand` and `est<STABLE-1`: `est<=est+1`, stay in FILTRA.
  - `s2==cand` and `est==STABLE-1`: accept. Go to ESTAVEL. If `cand!=valor`, then `valor<=cand` and `novo<=1`.
- ESTAVEL:
  - `s2==valor`: stay.
  - Otherwise: go to FILTRA with `cand<=s2` and `est<=0`.
- `en=0` in any state: go to OCIOSO next edge. A pending acceptance is discarded.
- On each acceptance with `cand!=valor`:
  - If old `valor` is all-ones and `cand` is 0: `volta<=1`, and `voltas<=voltas+1` unless it is already all-ones.
  - Sequence check (when compiled in): if `cand != valor+1` (mod 2^WIDTH), set `erro<=1`.
- `novo` and `volta` are registered pulses, exactly one cycle wide. Back-to-back acceptances cannot occur, because at least one FILTRA cycle separates them.
- Reset values:
  - `valor=0`, `novo=0`, `volta=0`, `voltas=0`, `erro=0`.
  - `s1=s2=0`, `cand=0`, `est=0`, state OCIOSO.
  - `valor=0` is a valid reference, matching the counter's own cleared value.

## Timing
- `q_in` settled before edge E1: `s2` holds the new value after E2.
- From ESTAVEL, mismatch is detected at E3 (FILTRA entered, `cand` loaded).
- Acceptance occurs at edge E(3+STABLE); `valor` updates and `novo` is high for the following cycle.
- Total latency is STABLE+3 edges; with `STABLE=2`, 5 edges.
- Glitch rejection: a `q_in` excursion visible on `s2` for fewer than STABLE+1 consecutive cycles is never accepted.
- `clr` low: all registers clear immediately, without waiting for `clk`. This includes mid-FILTRA and while `novo` is high.
- `clr` release: operation starts on the first edge with `clr=1`.
- `en` low for one cycle restarts filtering from OCIOSO. It does not alter `valor`, `voltas` or `erro`.
- Input counting faster than `clk/(STABLE+1)`: intermediate values are skipped. With the sequence check compiled in, this sets `erro`.

## Configuration
- Macro: `AMOSTRADOR_CONTADOR_SEQ_CHECK_EN`.
- Defined: the +1 sequence checker is compiled in; `erro` sets on any non-increment acceptance and clears only on `clr`.
- Undefined: the checker logic is absent, `erro` is tied to constant 0, and all other behaviour is identical.

## Test plan
- Reset: drive `clr=0` with `q_in=9` and `en=1`, then release; all outputs read 0 during reset. After release, `valor` reaches 9 in 5 edges.
- Step: `STABLE=2`, ESTAVEL with `valor=0`, `q_in` 0->1 before an edge. `valor=1` and `novo=1` for exactly one cycle, 5 edges later, with `volta=0`.
- Glitch: `valor=3`, `q_in` shows 7 for 1 clk period then returns to 3. `novo` never pulses, `valor` stays 3, and `erro` stays 0.
- Wrap: step `q_in` 0..15,0 with each value held 8 cycles.
  - Expect 16 `novo` pulses, one `volta` coincident with the 15->0 `novo`, and `voltas=1`.
  - Repeat 300 wraps: `voltas=255`.
- Sequence error: `valor=2`, `q_in` jumps to 5.
  - With the macro: `valor=5`, `erro=1`, still 1 after further legal steps.
  - Without the macro: `erro=0`.
- Mid-operation reset/enable:
  - Assert `clr` two cycles into FILTRA: outputs 0 immediately, no `novo` afterwards for the old candidate.
  - Drop `en` during FILTRA: `valor` unchanged and no `novo`.
